// File: rtl/multi_exchange_parser.sv
// Framed multi-exchange price parser: HEADER, payload, [checksum], FOOTER -> atomic price publish.
// Optional checksum byte support is enabled by defining CHECKSUM_EN.
module multi_exchange_parser #(
    parameter int unsigned NUM_EXCH       = 2,
    parameter int unsigned PRICE_BYTES    = 2,
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  FOOTER         = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic [NUM_EXCH*PRICE_BYTES*8-1:0] prices,
    output logic                              packet_valid,
    output logic                              frame_error,
    output logic [1:0]                        err_code,
    output logic [15:0]                       error_count
);

    localparam int unsigned TOTAL = NUM_EXCH * PRICE_BYTES;
    localparam int unsigned PW    = TOTAL * 8;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_FOOTER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_FOOTER} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [7:0]        shadow [TOTAL];
    logic              shadow_we;
    logic [PW-1:0]     shadow_flat;
    logic [PW-1:0]     prices_d;
    logic              packet_valid_d, frame_error_d;
    logic [1:0]        err_code_d;
    logic [15:0]       error_count_d;
    logic              err;
    logic [1:0]        err_cause;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Rearrange byte-ordered shadow into the exchange-major, MSB-first price bus.
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < TOTAL; i++) begin
            shadow_flat[((i / PRICE_BYTES) * PRICE_BYTES + (PRICE_BYTES - 1 - (i % PRICE_BYTES))) * 8 +: 8] = shadow[i];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        prices_d       = prices;
        packet_valid_d = 1'b0;
        frame_error_d  = 1'b0;
        err_code_d     = err_code;
        error_count_d  = error_count;
        shadow_we      = 1'b0;
        err            = 1'b0;
        err_cause      = 2'd0;
`ifdef CHECKSUM_EN
        csum_d         = csum_q;
`endif

        if (state_q == S_IDLE) begin
            if (rx_valid && rx_data == HEADER) begin
                state_d = S_PAYLOAD;
                cnt_d   = '0;
                timer_d = '0;
`ifdef CHECKSUM_EN
                csum_d  = 8'h00;
`endif
            end
        end else if (rx_valid) begin
            // A byte arriving on the limit cycle is accepted and restarts the timer.
            timer_d = '0;
            case (state_q)
                S_PAYLOAD: begin
                    shadow_we = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
`ifdef CHECKSUM_EN
                    csum_d    = csum_q ^ rx_data;
                    if (cnt_q == CNT_W'(TOTAL - 1)) state_d = S_CHECK;
`else
                    if (cnt_q == CNT_W'(TOTAL - 1)) state_d = S_FOOTER;
`endif
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (rx_data == csum_q) begin
                        state_d = S_FOOTER;
                    end else begin
                        err       = 1'b1;
                        err_cause = 2'd3;
                    end
                end
`endif
                S_FOOTER: begin
                    if (rx_data == FOOTER) begin
                        prices_d       = shadow_flat;
                        packet_valid_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        err       = 1'b1;
                        err_cause = 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            err       = 1'b1;
            err_cause = 2'd2;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (err) begin
            state_d       = S_IDLE;
            timer_d       = '0;
            frame_error_d = 1'b1;
            err_code_d    = err_cause;
            if (error_count != 16'hFFFF) error_count_d = error_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            prices       <= '0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            err_code     <= 2'd0;
            error_count  <= 16'd0;
`ifdef CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            prices       <= prices_d;
            packet_valid <= packet_valid_d;
            frame_error  <= frame_error_d;
            err_code     <= err_code_d;
            error_count  <= error_count_d;
`ifdef CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Shadow buffer holds the in-flight payload; only published on a good footer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TOTAL; i++) begin
            if (shadow_we && cnt_q == CNT_W'(i)) shadow[i] <= rx_data;
        end
    end

endmodule

// File: tb/tb_multi_exchange_parser.sv
// Directed bench for multi_exchange_parser: default 2x2 instance plus a 4x3 instance.
module tb_multi_exchange_parser;

    localparam int unsigned TO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] prices_a;
    logic        pv_a, fe_a;
    logic [1:0]  ec_a;
    logic [15:0] cnt_a;
    logic [95:0] prices_b;
    logic        pv_b, fe_b;
    logic [1:0]  ec_b;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_exchange_parser #(.NUM_EXCH(2), .PRICE_BYTES(2), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .prices(prices_a), .packet_valid(pv_a), .frame_error(fe_a),
        .err_code(ec_a), .error_count(cnt_a)
    );

    multi_exchange_parser #(.NUM_EXCH(4), .PRICE_BYTES(3), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .prices(prices_b), .packet_valid(pv_b), .frame_error(fe_b),
        .err_code(ec_b), .error_count(cnt_b)
    );

    // One-cycle strobe; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rx_data = 8'h00; rx_valid = 1'b0;
        do_reset();
        total++; if (prices_a !== 32'h0) begin bad++; $display("FAIL reset_prices got=%h want=%h", prices_a, 32'h0); end
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b want=0", pv_a); end
        total++; if (fe_a !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", fe_a); end
        total++; if (ec_a !== 2'd0) begin bad++; $display("FAIL reset_ec got=%0d want=0", ec_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_a); end
    endtask

    task automatic test_valid_frame();
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
`ifdef CHECKSUM_EN
        send_byte(8'h08);
`endif
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL valid_early_pv got=%b want=0", pv_a); end
        send_byte(8'h55);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL valid_pv got=%b want=1", pv_a); end
        total++; if (fe_a !== 1'b0) begin bad++; $display("FAIL valid_fe got=%b want=0", fe_a); end
        total++; if (prices_a !== 32'h5678_1234) begin bad++; $display("FAIL valid_prices got=%h want=%h", prices_a, 32'h5678_1234); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL valid_cnt got=%0d want=0", cnt_a); end
        idle(1);
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL valid_pulse_width got=%b want=0", pv_a); end
    endtask

    task automatic test_bad_footer();
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
`ifdef CHECKSUM_EN
        send_byte(8'h08);
`endif
        send_byte(8'h99);
        total++; if (fe_a !== 1'b1) begin bad++; $display("FAIL badftr_fe got=%b want=1", fe_a); end
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL badftr_pv got=%b want=0", pv_a); end
        total++; if (ec_a !== 2'd1) begin bad++; $display("FAIL badftr_ec got=%0d want=1", ec_a); end
        total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL badftr_cnt got=%0d want=1", cnt_a); end
        total++; if (prices_a !== 32'h5678_1234) begin bad++; $display("FAIL badftr_prices got=%h want=%h", prices_a, 32'h5678_1234); end
        idle(1);
        total++; if (fe_a !== 1'b0) begin bad++; $display("FAIL badftr_pulse_width got=%b want=0", fe_a); end
        total++; if (ec_a !== 2'd1) begin bad++; $display("FAIL badftr_ec_hold got=%0d want=1", ec_a); end
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
`ifdef CHECKSUM_EN
        send_byte(8'h03);
`endif
        send_byte(8'h55);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL recover_pv got=%b want=1", pv_a); end
        total++; if (prices_a !== 32'h0002_0001) begin bad++; $display("FAIL recover_prices got=%h want=%h", prices_a, 32'h0002_0001); end
    endtask

    task automatic test_timeout();
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34);
        idle(TO - 1);
        total++; if (fe_a !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", fe_a); end
        idle(1);
        total++; if (fe_a !== 1'b1) begin bad++; $display("FAIL timeout_fe got=%b want=1", fe_a); end
        total++; if (ec_a !== 2'd2) begin bad++; $display("FAIL timeout_ec got=%0d want=2", ec_a); end
        total++; if (cnt_a !== 16'd2) begin bad++; $display("FAIL timeout_cnt got=%0d want=2", cnt_a); end
        // Byte lands on the limit cycle itself and must win over the timeout.
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34);
        idle(TO - 1);
        send_byte(8'h56);
        total++; if (fe_a !== 1'b0) begin bad++; $display("FAIL timeout_limit_byte got=%b want=0", fe_a); end
        send_byte(8'h78);
`ifdef CHECKSUM_EN
        send_byte(8'h08);
`endif
        send_byte(8'h55);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL timeout_recover_pv got=%b want=1", pv_a); end
        total++; if (prices_a !== 32'h5678_1234) begin bad++; $display("FAIL timeout_recover_prices got=%h want=%h", prices_a, 32'h5678_1234); end
        total++; if (cnt_a !== 16'd2) begin bad++; $display("FAIL timeout_recover_cnt got=%0d want=2", cnt_a); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hAA); send_byte(8'h12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++; if (pv_a !== 1'b0 || fe_a !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%b%b want=00", pv_a, fe_a); end
        total++; if (prices_a !== 32'h0) begin bad++; $display("FAIL midrst_prices got=%h want=%h", prices_a, 32'h0); end
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'hAA);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef CHECKSUM_EN
        send_byte(8'hAA);
`endif
        send_byte(8'h55);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL midrst_pv got=%b want=1", pv_a); end
        total++; if (prices_a !== 32'h0000_AA00) begin bad++; $display("FAIL midrst_prices2 got=%h want=%h", prices_a, 32'h0000_AA00); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt_a); end
    endtask

    task automatic test_wide();
        do_reset();
        send_byte(8'hAA);
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
`ifdef CHECKSUM_EN
        send_byte(8'h0C);
`endif
        total++; if (prices_b !== 96'h0 || pv_b !== 1'b0) begin bad++; $display("FAIL wide_partial got=%h/%b want=0/0", prices_b, pv_b); end
        send_byte(8'h55);
        total++; if (pv_b !== 1'b1) begin bad++; $display("FAIL wide_pv got=%b want=1", pv_b); end
        total++; if (prices_b !== 96'h0A0B0C_070809_040506_010203) begin bad++; $display("FAIL wide_prices got=%h want=%h", prices_b, 96'h0A0B0C_070809_040506_010203); end
        total++; if (fe_b !== 1'b0) begin bad++; $display("FAIL wide_fe got=%b want=0", fe_b); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'hAA); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef CHECKSUM_EN
        send_byte(8'h44);
`endif
        send_byte(8'h55);
        send_byte(8'hAA);
        total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL b2b_pulse_width got=%b want=0", pv_a); end
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'hFF); send_byte(8'h01);
`ifdef CHECKSUM_EN
        send_byte(8'h01);
`endif
        send_byte(8'h55);
        total++; if (pv_a !== 1'b1) begin bad++; $display("FAIL b2b_pv got=%b want=1", pv_a); end
        total++; if (prices_a !== 32'hFF01_55AA) begin bad++; $display("FAIL b2b_prices got=%h want=%h", prices_a, 32'hFF01_55AA); end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h09);
        total++; if (fe_a !== 1'b1) begin bad++; $display("FAIL csum_fe got=%b want=1", fe_a); end
        total++; if (ec_a !== 2'd3) begin bad++; $display("FAIL csum_ec got=%0d want=3", ec_a); end
        total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL csum_cnt got=%0d want=1", cnt_a); end
    endtask
`endif

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        test_reset();
        test_valid_frame();
        test_bad_footer();
        test_timeout();
        test_reset_midframe();
        test_wide();
        test_back_to_back();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
